store_rmw_unit: RTL and testbench

//  Store-side partner of the load extractor: executes SB/SH/SW into a word-wide data memory that
//  has no byte enables. SW is a direct word write. SB/SH run a read-modify-write: read the word,

---
 rtl/store_rmw_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_store_rmw_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
//   Executes SB/SH/SW stores into a word-wide data memory without byte enables.
//   SW is a direct word write. SB/SH read the addressed word, merge the low
//   byte/half of the store data into the addressed little-endian lane and write
//   the merged word back.
//
// Parameters
//   RD_LAT          cycles from o_mem_re to valid i_mem_rdata (>= 1)
//
// Configuration macro
//   STORE_MISALIGN_TRAP_EN  when defined, SH with addr[0]=1 and SW with
//                           addr[1:0]!=0 are rejected with a one-cycle
//                           o_misalign_err pulse and no memory access.
//                           When undefined, o_misalign_err is tied low, SH uses
//                           addr[1] only and SW drops the low address bits.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_st_valid      store request valid
//   o_st_ready      unit idle, request accepted this cycle if valid
//   i_st_size       00 byte, 01 half, 10 word, 11 reserved (behaves as word)
//   i_st_addr       byte address
//   i_st_data       store data (rs2); low byte/half used for SB/SH
//   o_done          one-cycle pulse coincident with the memory write
//   o_misalign_err  one-cycle pulse on a rejected misaligned store
//   o_mem_addr      word-aligned memory address, 0 while idle
//   o_mem_re        one-cycle read strobe
//   i_mem_rdata     read data, valid RD_LAT cycles after o_mem_re
//   o_mem_we        one-cycle write strobe
//   o_mem_wdata     merged write word, 0 when o_mem_we=0
// -----------------------------------------------------------------------------
module store_rmw_unit #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_st_valid,
   output logic        o_st_ready,
   input  logic [1:0]  i_st_size,
   input  logic [31:0] i_st_addr,
   input  logic [31:0] i_st_data,
   output logic        o_done,
   output logic        o_misalign_err,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_re,
   input  logic [31:0] i_mem_rdata,
   output logic        o_mem_we,
   output logic [31:0] o_mem_wdata
);

   localparam int unsigned DW    = 32;
   localparam int unsigned WAW   = 30;
   localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WAIT  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   // Lane merge: byte/half replace one lane of the read word; word sizes
   // (including the reserved encoding) take the store data as is.
   function automatic logic [DW-1:0] f_merge(
      input logic [DW-1:0] word,
      input logic [DW-1:0] data,
      input logic [1:0]    size,
      input logic [1:0]    off
   );
      logic [DW-1:0] res;
      res = word;
      case (size)
         SZ_BYTE: res[{off, 3'b000} +: 8] = data[7:0];
         SZ_HALF: begin
            if (off[1]) res[31:16] = data[15:0];
            else        res[15:0]  = data[15:0];
         end
         default: res = data;
      endcase
      return res;
   endfunction

   // State and request registers
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_size;
   logic [1:0]        r_off;
   logic [DW-1:0]     r_data;
   logic [WAW-1:0]    r_addr;

   // Registered outputs
   logic              r_st_ready;
   logic              r_done;
   logic [DW-1:0]     r_mem_addr;
   logic              r_mem_re;
   logic              r_mem_we;
   logic [DW-1:0]     r_mem_wdata;

   // Next-state / next-output wires
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_accept;
   logic              w_in_word;
   logic [1:0]        w_m_size;
   logic [1:0]        w_m_off;
   logic [DW-1:0]     w_m_data;
   logic [WAW-1:0]    w_addr_src;
   logic [DW-1:0]     w_merged;
   logic              w_st_ready_nxt;
   logic              w_done_nxt;
   logic [DW-1:0]     w_mem_addr_nxt;
   logic              w_mem_re_nxt;
   logic              w_mem_we_nxt;
   logic [DW-1:0]     w_mem_wdata_nxt;

`ifdef STORE_MISALIGN_TRAP_EN
   logic              r_misalign_err;
   logic              w_trap;
   logic              w_in_misalign;

   // Half needs an even address, word needs a fully aligned one.
   assign w_in_misalign = ((i_st_size == SZ_HALF) && i_st_addr[0]) ||
                          (i_st_size[1] && (i_st_addr[1:0] != 2'b00));
`endif

   assign w_in_word = i_st_size[1];

   // Merge operands come straight from the request when writing from IDLE
   // (word path), otherwise from the latched request.
   assign w_m_size   = (r_state == S_IDLE) ? i_st_size       : r_size;
   assign w_m_off    = (r_state == S_IDLE) ? i_st_addr[1:0]  : r_off;
   assign w_m_data   = (r_state == S_IDLE) ? i_st_data       : r_data;
   assign w_addr_src = (r_state == S_IDLE) ? i_st_addr[31:2] : r_addr;
   assign w_merged   = f_merge(i_mem_rdata, w_m_data, w_m_size, w_m_off);

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      w_trap      = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_st_valid) begin
               w_accept = 1'b1;
               if (w_in_word) w_state_nxt = S_WRITE;
               else           w_state_nxt = S_READ;
`ifdef STORE_MISALIGN_TRAP_EN
               if (w_in_misalign) begin
                  w_trap      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
`endif
            end
         end
         S_READ: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
         end
         S_WAIT: begin
            // Read data is valid on the RD_LAT-th WAIT cycle; the merge is
            // captured into the write-data register on that edge.
            if (r_cnt == CNT_LAST) w_state_nxt = S_WRITE;
            else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
         end
         S_WRITE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered as a function of the state being entered.
   always_comb begin
      w_st_ready_nxt  = 1'b0;
      w_done_nxt      = 1'b0;
      w_mem_re_nxt    = 1'b0;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = '0;
      w_mem_wdata_nxt = '0;
      case (w_state_nxt)
         S_IDLE: begin
            w_st_ready_nxt = 1'b1;
         end
         S_READ: begin
            w_mem_re_nxt   = 1'b1;
            w_mem_addr_nxt = {w_addr_src, 2'b00};
         end
         S_WAIT: begin
            w_mem_addr_nxt = {w_addr_src, 2'b00};
         end
         S_WRITE: begin
            w_mem_we_nxt    = 1'b1;
            w_done_nxt      = 1'b1;
            w_mem_addr_nxt  = {w_addr_src, 2'b00};
            w_mem_wdata_nxt = w_merged;
         end
         default: begin
            w_st_ready_nxt = 1'b1;
         end
      endcase
   end

   // State, request and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_size      <= '0;
         r_off       <= '0;
         r_data      <= '0;
         r_addr      <= '0;
         r_st_ready  <= 1'b1;
         r_done      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_st_ready  <= w_st_ready_nxt;
         r_done      <= w_done_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_re    <= w_mem_re_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         if (w_accept) begin
            r_size <= i_st_size;
            r_off  <= i_st_addr[1:0];
            r_data <= i_st_data;
            r_addr <= i_st_addr[31:2];
         end
      end
   end

`ifdef STORE_MISALIGN_TRAP_EN
   // Rejection pulse for misaligned requests
   always_ff @(posedge i_clk) begin
      if (i_rst) r_misalign_err <= 1'b0;
      else       r_misalign_err <= w_trap;
   end

   assign o_misalign_err = r_misalign_err;
`else
   assign o_misalign_err = 1'b0;
`endif

   assign o_st_ready  = r_st_ready;
   assign o_done      = r_done;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_re    = r_mem_re;
   assign o_mem_we    = r_mem_we;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_rmw_unit.sv
// -----------------------------------------------------------------------------
// tb_store_rmw_unit
//   Two store_rmw_unit instances (RD_LAT=1 and RD_LAT=3), each attached to a
//   small behavioural memory with the specified read latency. A reference
//   memory image predicts every merged write word from lane arithmetic.
//   Honours STORE_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_store_rmw_unit;

   localparam int NU = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        st_valid  [NU];
   logic        st_ready  [NU];
   logic [1:0]  st_size   [NU];
   logic [31:0] st_addr   [NU];
   logic [31:0] st_data   [NU];
   logic        done      [NU];
   logic        mis_err   [NU];
   logic [31:0] mem_addr  [NU];
   logic        mem_re    [NU];
   logic [31:0] mem_rdata [NU];
   logic        mem_we    [NU];
   logic [31:0] mem_wdata [NU];

   logic [31:0] mem     [NU][256];
   logic [31:0] ref_mem [NU][256];
   logic [2:0]  rd_vld  [NU];
   logic [7:0]  rd_idx  [NU][3];
   logic [31:0] noise   [NU];
   logic        mem_init;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   function automatic int lat_of(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] init_word(input int u, input int i);
      return (32'(i) * 32'h9E37_79B1) ^ (32'(u) * 32'h5A5A_0F0F) ^ 32'h0BAD_F00D;
   endfunction

   for (genvar g = 0; g < NU; g++) begin : g_dut
      store_rmw_unit #(.RD_LAT((g == 0) ? 1 : 3)) u_dut (
         .i_clk          (clk),
         .i_rst          (rst),
         .i_st_valid     (st_valid[g]),
         .o_st_ready     (st_ready[g]),
         .i_st_size      (st_size[g]),
         .i_st_addr      (st_addr[g]),
         .i_st_data      (st_data[g]),
         .o_done         (done[g]),
         .o_misalign_err (mis_err[g]),
         .o_mem_addr     (mem_addr[g]),
         .o_mem_re       (mem_re[g]),
         .i_mem_rdata    (mem_rdata[g]),
         .o_mem_we       (mem_we[g]),
         .o_mem_wdata    (mem_wdata[g])
      );
   end

   // Memory environment: word array indexed by addr[9:2], read pipeline of
   // depth RD_LAT, random noise on the read bus when no read data is due.
   always @(posedge clk) begin
      for (int u = 0; u < NU; u++) begin
         if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[u][i] <= init_word(u, i);
         end else if (mem_we[u] === 1'b1) begin
            mem[u][mem_addr[u][9:2]] <= mem_wdata[u];
         end
         rd_vld[u]    <= {rd_vld[u][1:0], mem_re[u] === 1'b1};
         rd_idx[u][2] <= rd_idx[u][1];
         rd_idx[u][1] <= rd_idx[u][0];
         rd_idx[u][0] <= mem_addr[u][9:2];
         noise[u]     <= $urandom;
      end
   end

   always_comb begin
      for (int u = 0; u < NU; u++) begin
         mem_rdata[u] = rd_vld[u][lat_of(u) - 1] ? mem[u][rd_idx[u][lat_of(u) - 1]] : noise[u];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One store on unit u, checked cycle by cycle. rst_at>0 asserts reset at
   // that cycle of the operation and verifies the store is abandoned.
   task automatic do_store(input int u, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input int rst_at);
      logic [7:0]  idx;
      logic [1:0]  off;
      logic [31:0] old, expw, mask, waddr;
      int          sh, lat;
      bit          is_word, trap;
      string       t;

      idx     = addr[9:2];
      off     = addr[1:0];
      waddr   = {addr[31:2], 2'b00};
      old     = ref_mem[u][idx];
      is_word = (size == 2'd2) || (size == 2'd3);
      trap    = 1'b0;
      if (size == 2'd0) begin
         sh   = 8 * int'(off);
         mask = 32'h0000_00FF << sh;
         expw = (old & ~mask) | ((data & 32'h0000_00FF) << sh);
      end else if (size == 2'd1) begin
         sh   = (int'(off) >= 2) ? 16 : 0;
         mask = 32'h0000_FFFF << sh;
         expw = (old & ~mask) | ((data & 32'h0000_FFFF) << sh);
`ifdef STORE_MISALIGN_TRAP_EN
         trap = (int'(off) % 2) != 0;
`endif
      end else begin
         expw = data;
`ifdef STORE_MISALIGN_TRAP_EN
         trap = int'(off) != 0;
`endif
      end
      lat = is_word ? 1 : 2 + lat_of(u);
      t   = $sformatf("u%0d sz%0d a%h", u, size, addr);

      chk({t, " ready@c0"}, 32'(st_ready[u]), 32'd1);
      st_valid[u] = 1'b1;
      st_size[u]  = size;
      st_addr[u]  = addr;
      st_data[u]  = data;
      @(posedge clk);

      if (trap) begin
         @(negedge clk);
         st_valid[u] = 1'b0;
         chk({t, " trap err"},  32'(mis_err[u]), 32'd1);
         chk({t, " trap re"},   32'(mem_re[u]),  32'd0);
         chk({t, " trap we"},   32'(mem_we[u]),  32'd0);
         chk({t, " trap done"}, 32'(done[u]),    32'd0);
         @(negedge clk);
         chk({t, " trap err end"}, 32'(mis_err[u]), 32'd0);
         chk({t, " trap we end"},  32'(mem_we[u]),  32'd0);
         chk({t, " trap ready"},   32'(st_ready[u]), 32'd1);
         return;
      end

      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         chk($sformatf("%s ready c%0d", t, k), 32'(st_ready[u]), 32'd0);
         chk($sformatf("%s re c%0d", t, k),    32'(mem_re[u]), 32'((!is_word) && (k == 1)));
         chk($sformatf("%s we c%0d", t, k),    32'(mem_we[u]), 32'(k == lat));
         chk($sformatf("%s done c%0d", t, k),  32'(done[u]),   32'(k == lat));
         chk($sformatf("%s err c%0d", t, k),   32'(mis_err[u]), 32'd0);
         chk($sformatf("%s addr c%0d", t, k),  mem_addr[u], waddr);
         chk($sformatf("%s wdata c%0d", t, k), mem_wdata[u], (k == lat) ? expw : 32'd0);
         if (rst_at == k) begin
            rst         = 1'b1;
            st_valid[u] = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk({t, " rst ready"}, 32'(st_ready[u]), 32'd1);
            chk({t, " rst re"},    32'(mem_re[u]),   32'd0);
            chk({t, " rst we"},    32'(mem_we[u]),   32'd0);
            chk({t, " rst done"},  32'(done[u]),     32'd0);
            chk({t, " rst err"},   32'(mis_err[u]),  32'd0);
            chk({t, " rst addr"},  mem_addr[u],      32'd0);
            chk({t, " rst wdata"}, mem_wdata[u],     32'd0);
            for (int j = 0; j < 8; j++) begin
               @(negedge clk);
               chk($sformatf("%s post-rst we %0d", t, j), 32'(mem_we[u]), 32'd0);
               chk($sformatf("%s post-rst re %0d", t, j), 32'(mem_re[u]), 32'd0);
            end
            return;
         end
         if (k < lat) begin
            // Requests while busy must be ignored.
            st_valid[u] = 1'b1;
            st_size[u]  = 2'($urandom);
            st_addr[u]  = $urandom;
            st_data[u]  = $urandom;
         end else begin
            st_valid[u] = 1'b0;
         end
      end
      ref_mem[u][idx] = expw;
      @(negedge clk);
      chk({t, " idle ready"}, 32'(st_ready[u]), 32'd1);
      chk({t, " idle addr"},  mem_addr[u],      32'd0);
      chk({t, " idle we"},    32'(mem_we[u]),   32'd0);
      chk({t, " idle wdata"}, mem_wdata[u],     32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      mem_init = 1'b1;
      for (int u = 0; u < NU; u++) begin
         st_valid[u] = 1'b0;
         st_size[u]  = 2'd0;
         st_addr[u]  = 32'd0;
         st_data[u]  = 32'd0;
         for (int i = 0; i < 256; i++) ref_mem[u][i] = init_word(u, i);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         chk($sformatf("reset u%0d ready", u), 32'(st_ready[u]), 32'd1);
         chk($sformatf("reset u%0d done", u),  32'(done[u]),     32'd0);
         chk($sformatf("reset u%0d err", u),   32'(mis_err[u]),  32'd0);
         chk($sformatf("reset u%0d re", u),    32'(mem_re[u]),   32'd0);
         chk($sformatf("reset u%0d we", u),    32'(mem_we[u]),   32'd0);
         chk($sformatf("reset u%0d addr", u),  mem_addr[u],      32'd0);
         chk($sformatf("reset u%0d wdata", u), mem_wdata[u],     32'd0);
      end
      rst      = 1'b0;
      mem_init = 1'b0;

      // SW direct write
      do_store(0, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0);
      chk("sw mem", mem[0][8'h40], 32'hDEAD_BEEF);

      // SB into top byte
      do_store(0, 2'd2, 32'h0000_0100, 32'h1122_3344, 0);
      do_store(0, 2'd0, 32'h0000_0103, 32'h0000_00AB, 0);
      chk("sb mem", mem[0][8'h40], 32'hAB22_3344);

      // SH upper and lower half
      do_store(0, 2'd2, 32'h0000_0200, 32'h1122_3344, 0);
      do_store(0, 2'd1, 32'h0000_0202, 32'h0000_CAFE, 0);
      chk("sh hi mem", mem[0][8'h80], 32'hCAFE_3344);
      do_store(0, 2'd2, 32'h0000_0200, 32'h1122_3344, 0);
      do_store(0, 2'd1, 32'h0000_0200, 32'h0000_CAFE, 0);
      chk("sh lo mem", mem[0][8'h80], 32'h1122_CAFE);

      // Reserved size behaves as word
      do_store(0, 2'd3, 32'h0000_0010, 32'h0123_4567, 0);
      chk("sz11 mem", mem[0][8'h04], 32'h0123_4567);

      // RD_LAT=3 byte store
      do_store(1, 2'd2, 32'h0000_0000, 32'h0000_0000, 0);
      do_store(1, 2'd0, 32'h0000_0001, 32'h0000_0055, 0);
      chk("lat3 sb mem", mem[1][8'h00], 32'h0000_5500);

      // Reset while waiting for read data
      do_store(1, 2'd0, 32'h0000_0005, 32'h0000_0077, 2);
      chk("rst mem untouched", mem[1][8'h01], init_word(1, 1));

      // Misaligned half
      do_store(0, 2'd2, 32'h0000_0100, 32'h1122_3344, 0);
      do_store(0, 2'd1, 32'h0000_0101, 32'h0000_BEEF, 0);
`ifdef STORE_MISALIGN_TRAP_EN
      chk("misalign sh mem", mem[0][8'h40], 32'h1122_3344);
`else
      chk("misalign sh mem", mem[0][8'h40], 32'h1122_BEEF);
`endif

      // Randomized stores on both latencies
      for (int n = 0; n < 60; n++) begin
         do_store(n % 2, 2'($urandom_range(0, 3)), $urandom, $urandom, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
